// File: rtl/render_pkg.sv
// render_pkg: shared definitions for the vertex scheduling block.
//   - Default parameter values for vertex_scheduler.
//   - Scheduler state encoding.
//   - Step-request decode helper (one step pulse only when exactly one
//     direction is pending).
package render_pkg;

    localparam int DEF_NUM_VERTICES  = 256;
    localparam int DEF_ADDR_W        = 8;
    localparam int DEF_BRAM_LATENCY  = 2;
    localparam int DEF_SETTLE_CYCLES = 20;
    localparam int DEF_DRAIN_TIMEOUT = 64;

    localparam int RET_CNT_W  = 16;
    localparam int WAIT_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ANGLE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_DRAIN  = 3'd4
    } sched_state_e;

    typedef struct packed {
        logic inc;
        logic dec;
    } step_t;

    // Opposing requests cancel each other out.
    function automatic step_t step_decode(input logic inc_pend, input logic dec_pend);
        step_t step;
        step.inc = inc_pend & ~dec_pend;
        step.dec = dec_pend & ~inc_pend;
        return step;
    endfunction

endpackage

// File: rtl/valid_pipe.sv
// valid_pipe: fixed-depth delay line for a single valid strobe.
//   clk_in    : system clock
//   rst_in    : synchronous active-low reset, clears every stage
//   valid_in  : strobe to delay
//   valid_out : valid_in delayed by exactly DEPTH cycles (DEPTH=0 is a wire)
module valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic valid_in,
    output logic valid_out
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign valid_out = valid_in;
        end else begin : g_pipe
            logic [DEPTH-1:0] pipe_r;

            // Shift the strobe one stage per cycle.
            always_ff @(posedge clk_in) begin
                if (!rst_in) begin
                    pipe_r <= {DEPTH{1'b0}};
                end else begin
                    pipe_r <= (pipe_r << 1) | DEPTH'(valid_in);
                end
            end

            assign valid_out = pipe_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vertex_scheduler.sv
// vertex_scheduler: sequences one frame pass over the vertex memory.
//   An optional rotation step is issued first (ANGLE), the rotation datapath
//   is given time to settle (SETTLE), every vertex address is issued once
//   (ISSUE) and the projected results are counted back in (DRAIN).
// Ports:
//   clk_in, rst_in            : clock, synchronous active-low reset
//   frame_start_in            : pulse requesting a frame pass
//   inc_req_in, dec_req_in    : rotate-step request pulses (sticky)
//   inc_out, dec_out          : one-cycle step pulses to the datapath
//   addr_out                  : vertex memory read address
//   vtx_valid_out             : memory read data valid (issue delayed by BRAM_LATENCY)
//   proj_valid_in             : projected-vertex valid from the datapath
//   busy_out                  : high whenever not idle
//   frame_done_out            : pulse when all vertices returned
//   overrun_out               : pulse when a frame start was dropped
//   timeout_out               : pulse when DRAIN gave up
module vertex_scheduler
    import render_pkg::*;
#(
    parameter int NUM_VERTICES  = DEF_NUM_VERTICES,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int BRAM_LATENCY  = DEF_BRAM_LATENCY,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              frame_start_in,
    input  logic              inc_req_in,
    input  logic              dec_req_in,
    output logic              inc_out,
    output logic              dec_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              vtx_valid_out,
    input  logic              proj_valid_in,
    output logic              busy_out,
    output logic              frame_done_out,
    output logic              overrun_out,
    output logic              timeout_out
);

    localparam logic [ADDR_W-1:0]     LAST_ADDR   = ADDR_W'(NUM_VERTICES - 1);
    localparam logic [WAIT_CNT_W-1:0] SETTLE_LAST = WAIT_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WAIT_CNT_W-1:0] DRAIN_LAST  = WAIT_CNT_W'(DRAIN_TIMEOUT - 1);

    sched_state_e          state_r;
    sched_state_e          state_next_s;
    logic                  inc_pend_r;
    logic                  dec_pend_r;
    step_t                 start_step_s;
    logic                  start_s;
    logic                  enter_issue_s;
    logic                  ret_reached_s;
    logic                  drain_done_s;
    logic                  drain_tmo_s;
    logic                  issue_s;
    logic                  vtx_valid_s;
    logic [WAIT_CNT_W-1:0] wait_cnt_r;
    logic [RET_CNT_W-1:0]  ret_cnt_r;
    logic [ADDR_W-1:0]     addr_r;
    logic                  inc_r;
    logic                  dec_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  overrun_r;
    logic                  timeout_r;

    assign start_s       = (state_r == ST_IDLE) && frame_start_in;
    // A request arriving in the start cycle itself still counts for this frame.
    assign start_step_s  = step_decode(inc_pend_r | inc_req_in, dec_pend_r | dec_req_in);
    assign enter_issue_s = (state_next_s == ST_ISSUE) && (state_r != ST_ISSUE);
    assign ret_reached_s = ({{(32-RET_CNT_W){1'b0}}, ret_cnt_r} >= 32'(NUM_VERTICES));
    assign issue_s       = (state_r == ST_ISSUE);

    // Next-state decode and DRAIN exit classification.
    always_comb begin
        state_next_s = state_r;
        drain_done_s = 1'b0;
        drain_tmo_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frame_start_in) begin
                    state_next_s = ST_ANGLE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ANGLE: begin
                // inc_r/dec_r are the step pulses being driven in this cycle.
                if (inc_r || dec_r) begin
                    state_next_s = ST_SETTLE;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_SETTLE: begin
                if (wait_cnt_r == SETTLE_LAST) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_SETTLE;
                end
            end
            ST_ISSUE: begin
                if (addr_r == LAST_ADDR) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                // A complete return wins over a timeout landing in the same cycle.
                if (ret_reached_s) begin
                    state_next_s = ST_IDLE;
                    drain_done_s = 1'b1;
                end else if (wait_cnt_r == DRAIN_LAST) begin
                    state_next_s = ST_IDLE;
                    drain_tmo_s  = 1'b1;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus dwell, address and return counters.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= {WAIT_CNT_W{1'b0}};
            ret_cnt_r  <= {RET_CNT_W{1'b0}};
            addr_r     <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_next_s;

            if (state_next_s != state_r) begin
                wait_cnt_r <= {WAIT_CNT_W{1'b0}};
            end else if ((state_r == ST_SETTLE) || (state_r == ST_DRAIN)) begin
                wait_cnt_r <= wait_cnt_r + WAIT_CNT_W'(1);
            end else begin
                wait_cnt_r <= {WAIT_CNT_W{1'b0}};
            end

            // Returns seen while idle are stale and must not count.
            if (enter_issue_s) begin
                ret_cnt_r <= {RET_CNT_W{1'b0}};
            end else if (proj_valid_in && (state_r != ST_IDLE)) begin
                ret_cnt_r <= ret_cnt_r + RET_CNT_W'(1);
            end else begin
                ret_cnt_r <= ret_cnt_r;
            end

            // Address parks at 0 outside ISSUE so every frame starts from 0.
            if (issue_s && (state_next_s == ST_ISSUE)) begin
                addr_r <= addr_r + ADDR_W'(1);
            end else begin
                addr_r <= {ADDR_W{1'b0}};
            end
        end
    end

    // Sticky step requests, consumed when a frame enters ANGLE.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            inc_pend_r <= 1'b0;
            dec_pend_r <= 1'b0;
        end else if (start_s) begin
            inc_pend_r <= 1'b0;
            dec_pend_r <= 1'b0;
        end else begin
            inc_pend_r <= inc_pend_r | inc_req_in;
            dec_pend_r <= dec_pend_r | dec_req_in;
        end
    end

    // Registered status and step pulses, aligned with the state they describe.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            inc_r     <= 1'b0;
            dec_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            inc_r     <= start_s & start_step_s.inc;
            dec_r     <= start_s & start_step_s.dec;
            busy_r    <= (state_next_s != ST_IDLE);
            done_r    <= drain_done_s;
            timeout_r <= drain_tmo_s;
            // Also covers a start landing on the DRAIN exit cycle.
            overrun_r <= frame_start_in && (state_r != ST_IDLE);
        end
    end

    valid_pipe #(
        .DEPTH (BRAM_LATENCY)
    ) u_valid_pipe (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .valid_in  (issue_s),
        .valid_out (vtx_valid_s)
    );

    assign inc_out        = inc_r;
    assign dec_out        = dec_r;
    assign addr_out       = addr_r;
    assign vtx_valid_out  = vtx_valid_s;
    assign busy_out       = busy_r;
    assign frame_done_out = done_r;
    assign overrun_out    = overrun_r;
    assign timeout_out    = timeout_r;

endmodule

// File: tb/tb_vertex_scheduler.sv
// Scoreboard bench for vertex_scheduler: stimulus pushes expected events
// (vertex strobes, status pulses, whole-output snapshots) tagged with the
// cycle they are due; a negedge monitor matches what the DUT presents.
module tb_vertex_scheduler;

    localparam int NV = 256;
    localparam int K_INC = 0;
    localparam int K_DEC = 1;
    localparam int K_OVR = 2;
    localparam int K_DONE = 3;
    localparam int K_TMO = 4;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       frame_start_in;
    logic       inc_req_in;
    logic       dec_req_in;
    logic       inc_out;
    logic       dec_out;
    logic [7:0] addr_out;
    logic       vtx_valid_out;
    logic       proj_valid_in = 1'b0;
    logic       busy_out;
    logic       frame_done_out;
    logic       overrun_out;
    logic       timeout_out;

    typedef struct { int cyc; int addr; } vtx_exp_t;
    typedef struct { int cyc; int kind; } pulse_exp_t;
    typedef struct { int cyc; logic [14:0] vec; } snap_exp_t;

    vtx_exp_t   vtx_q[$];
    pulse_exp_t pulse_q[$];
    snap_exp_t  snap_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int hist0 = 0, hist1 = 0, hist2 = 0;
    int echo_cnt = 0;
    int echo_limit = NV;
    logic echo_prev = 1'b0;
    int p;

    vertex_scheduler dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .frame_start_in (frame_start_in),
        .inc_req_in     (inc_req_in),
        .dec_req_in     (dec_req_in),
        .inc_out        (inc_out),
        .dec_out        (dec_out),
        .addr_out       (addr_out),
        .vtx_valid_out  (vtx_valid_out),
        .proj_valid_in  (proj_valid_in),
        .busy_out       (busy_out),
        .frame_done_out (frame_done_out),
        .overrun_out    (overrun_out),
        .timeout_out    (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_INC:   return "inc_out";
            K_DEC:   return "dec_out";
            K_OVR:   return "overrun_out";
            K_DONE:  return "frame_done_out";
            default: return "timeout_out";
        endcase
    endfunction

    function automatic logic [14:0] mk(input logic busy, input logic inc, input logic dec,
                                       input logic vtx, input int addr);
        logic [7:0] a;
        a = addr[7:0];
        return {busy, inc, dec, vtx, 3'b000, a};
    endfunction

    // Monitor: match DUT outputs against the scoreboard every negedge.
    logic [14:0] cur_vec;
    logic [4:0]  obs;
    vtx_exp_t    ve;
    int          idx;
    always @(negedge clk_in) begin
        hist2 = hist1;
        hist1 = hist0;
        hist0 = int'(addr_out);
        cur_vec = {busy_out, inc_out, dec_out, vtx_valid_out,
                   frame_done_out, overrun_out, timeout_out, addr_out};
        for (int i = snap_q.size() - 1; i >= 0; i--) begin
            if (snap_q[i].cyc == cyc) begin
                n_checks++;
                if (cur_vec !== snap_q[i].vec) begin
                    n_fail++;
                    $display("FAIL snapshot cyc=%0d got=%h expected=%h", cyc, cur_vec, snap_q[i].vec);
                end
                snap_q.delete(i);
            end
        end
        while (vtx_q.size() > 0 && vtx_q[0].cyc < cyc) begin
            ve = vtx_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL vtx_missing cyc=%0d got=none expected addr %0d", ve.cyc, ve.addr);
        end
        if (vtx_valid_out === 1'b1) begin
            n_checks++;
            if (vtx_q.size() == 0) begin
                n_fail++;
                $display("FAIL vtx_unexpected cyc=%0d got addr %0d expected=none", cyc, hist2);
            end else begin
                ve = vtx_q.pop_front();
                if (ve.cyc != cyc || ve.addr != hist2) begin
                    n_fail++;
                    $display("FAIL vtx cyc=%0d got addr %0d expected addr %0d at cyc %0d",
                             cyc, hist2, ve.addr, ve.cyc);
                end
            end
        end
        obs = {timeout_out, frame_done_out, overrun_out, dec_out, inc_out};
        for (int k = 0; k < 5; k++) begin
            if (obs[k] !== 1'b0) begin
                n_checks++;
                idx = -1;
                for (int i = 0; i < pulse_q.size(); i++) begin
                    if (idx < 0 && pulse_q[i].kind == k && pulse_q[i].cyc == cyc) idx = i;
                end
                if (idx < 0) begin
                    n_fail++;
                    $display("FAIL pulse_unexpected %s cyc=%0d got=%b expected=0", kname(k), cyc, obs[k]);
                end else begin
                    pulse_q.delete(idx);
                end
            end
        end
        for (int i = pulse_q.size() - 1; i >= 0; i--) begin
            if (pulse_q[i].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL pulse_missing %s at cyc=%0d got=0 expected=1",
                         kname(pulse_q[i].kind), pulse_q[i].cyc);
                pulse_q.delete(i);
            end
        end
    end

    // Datapath model: echoes each vertex strobe one cycle later, up to echo_limit per frame.
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            proj_valid_in = echo_prev && (echo_cnt < echo_limit);
            if (proj_valid_in) echo_cnt++;
            echo_prev = vtx_valid_out;
            if (busy_out == 1'b0) echo_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick();
    endtask

    task automatic push_pulse(input int kind, input int c);
        pulse_q.push_back('{c, kind});
    endtask

    task automatic push_snap(input int c, input logic [14:0] v);
        snap_q.push_back('{c, v});
    endtask

    // Start a frame; step: 0 none, 1 inc, 2 dec. ending: 0 none, 1 done, 2 timeout.
    task automatic start_frame(input int step, input int nvtx, input int ending, output int pc);
        int first_vtx;
        int drain_start;
        pc = cyc;
        frame_start_in = 1'b1;
        first_vtx = pc + 4 + ((step != 0) ? 20 : 0);
        drain_start = first_vtx - 2 + NV;
        for (int i = 0; i < nvtx; i++) vtx_q.push_back('{first_vtx + i, i});
        push_snap(pc + 1, mk(1'b1, step == 1, step == 2, 1'b0, 0));
        if (step == 1) push_pulse(K_INC, pc + 1);
        if (step == 2) push_pulse(K_DEC, pc + 1);
        if (step != 0) push_snap(pc + 21, mk(1'b1, 1'b0, 1'b0, 1'b0, 0));
        push_snap(first_vtx + 6, mk(1'b1, 1'b0, 1'b0, 1'b1, 8));
        if (ending == 1) begin
            push_pulse(K_DONE, first_vtx + NV - 1 + 3);
            push_snap(first_vtx + NV - 1 + 4, 15'd0);
        end else if (ending == 2) begin
            push_pulse(K_TMO, drain_start + 64);
            push_snap(drain_start + 65, 15'd0);
        end
        tick();
        frame_start_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_out !== 1'b0 && n < 600) begin
            tick();
            n++;
        end
        n_checks++;
        if (busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_wait cyc=%0d got busy=%b expected=0", cyc, busy_out);
        end
        repeat (4) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in = 1'b0;
        frame_start_in = 1'b0;
        inc_req_in = 1'b0;
        dec_req_in = 1'b0;
        // Reset state; a start sampled while in reset is not honoured.
        push_snap(1, 15'd0);
        push_snap(3, 15'd0);
        push_snap(5, 15'd0);
        tick();
        tick();
        frame_start_in = 1'b1;
        tick();
        rst_in = 1'b1;
        frame_start_in = 1'b0;
        repeat (3) tick();

        // Plain frame, no step requests.
        start_frame(0, NV, 1, p);
        wait_idle();

        // inc request in IDLE -> inc pulse then 20-cycle settle.
        inc_req_in = 1'b1;
        tick();
        inc_req_in = 1'b0;
        tick();
        start_frame(1, NV, 1, p);
        wait_idle();

        // Both pending -> no step, no settle; dec request mid-ISSUE stays sticky;
        // frame start mid-ISSUE is an overrun.
        inc_req_in = 1'b1;
        tick();
        inc_req_in = 1'b0;
        dec_req_in = 1'b1;
        tick();
        dec_req_in = 1'b0;
        start_frame(0, NV, 1, p);
        wait_cyc(p + 50);
        dec_req_in = 1'b1;
        tick();
        dec_req_in = 1'b0;
        wait_cyc(p + 102);
        frame_start_in = 1'b1;
        push_pulse(K_OVR, p + 103);
        tick();
        frame_start_in = 1'b0;
        wait_idle();

        // Sticky dec from the previous frame.
        start_frame(2, NV, 1, p);
        wait_idle();

        // Only 250 returns -> timeout; start on the DRAIN exit cycle is an overrun.
        echo_limit = 250;
        start_frame(0, NV, 2, p);
        wait_cyc(p + 321);
        frame_start_in = 1'b1;
        push_pulse(K_OVR, p + 322);
        tick();
        frame_start_in = 1'b0;
        wait_idle();
        echo_limit = NV;

        // Reset while addr_out shows 100, then a fresh full frame.
        start_frame(0, 99, 0, p);
        wait_cyc(p + 102);
        rst_in = 1'b0;
        push_snap(p + 103, 15'd0);
        push_snap(p + 104, 15'd0);
        tick();
        tick();
        rst_in = 1'b1;
        repeat (3) tick();
        start_frame(0, NV, 1, p);
        wait_idle();

        repeat (10) tick();
        foreach (vtx_q[i]) begin
            n_checks++;
            n_fail++;
            $display("FAIL vtx_leftover cyc=%0d got=none expected addr %0d", vtx_q[i].cyc, vtx_q[i].addr);
        end
        foreach (pulse_q[i]) begin
            n_checks++;
            n_fail++;
            $display("FAIL pulse_leftover %s cyc=%0d got=none expected=1", kname(pulse_q[i].kind), pulse_q[i].cyc);
        end
        foreach (snap_q[i]) begin
            n_checks++;
            n_fail++;
            $display("FAIL snapshot_leftover cyc=%0d got=none expected=%h", snap_q[i].cyc, snap_q[i].vec);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vertex_scheduler.md
VERTEX_SCHEDULER -- requirements
Module: vertex_scheduler

Interface
REQ-001 Parameter NUM_VERTICES, default 256: vertex count per frame, range 1..2^ADDR_W.
REQ-002 Parameter ADDR_W, default 8: vertex memory address width.
REQ-003 Parameter BRAM_LATENCY, default 2: vertex memory read latency in cycles.
REQ-004 Parameter SETTLE_CYCLES, default 20: wait after an angle step, covering CORDIC latency.
REQ-005 Parameter DRAIN_TIMEOUT, default 64: maximum DRAIN cycles before abort.
REQ-006 Port clk_in, input, 1: single system clock.
REQ-007 Port rst_in, input, 1: synchronous, active-low reset.
REQ-008 Port frame_start_in, input, 1: one-cycle pulse requesting a frame pass.
REQ-009 Ports inc_req_in and dec_req_in, input, 1 each: rotate-step request pulses.
REQ-010 Ports inc_out and dec_out, output, 1 each: one-cycle step pulses to the rotation datapath.
REQ-011 Port addr_out, output, ADDR_W: vertex memory read address.
REQ-012 Port vtx_valid_out, output, 1: high when vertex memory data presented to the datapath is valid.
REQ-013 Port proj_valid_in, input, 1: projected-vertex valid returned from the datapath.
REQ-014 Ports busy_out, frame_done_out, overrun_out, timeout_out, output, 1 each: status outputs.

Function
REQ-015 States SHALL be IDLE, ANGLE, SETTLE, ISSUE and DRAIN.
REQ-016 inc_req_in and dec_req_in SHALL set sticky pending flags in any state; the flags clear only on entry to ANGLE.
REQ-017 IDLE to ANGLE SHALL occur on frame_start_in; busy_out SHALL be high in every state except IDLE.
REQ-018 In ANGLE (1 cycle), with exactly one flag pending, the matching step output SHALL pulse for 1 cycle, then go to SETTLE; with both or neither pending, no pulse, go directly to ISSUE.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to ISSUE.
REQ-020 ISSUE SHALL drive addr_out 0..NUM_VERTICES-1, one per cycle, with no gaps.
REQ-021 vtx_valid_out SHALL be the per-cycle issue strobe delayed by exactly BRAM_LATENCY cycles.
REQ-022 After the last address, go to DRAIN.
REQ-023 A 16-bit return counter SHALL increment on each proj_valid_in, cleared on entry to ISSUE.
REQ-024 DRAIN SHALL exit to IDLE when the counter reaches NUM_VERTICES, pulsing frame_done_out for 1 cycle.
REQ-025 DRAIN SHALL exit to IDLE with a 1-cycle timeout_out pulse, and no frame_done_out, after DRAIN_TIMEOUT cycles.
REQ-026 frame_start_in while busy_out is high SHALL be dropped, with a 1-cycle overrun_out pulse.
REQ-027 proj_valid_in in IDLE SHALL be ignored.
REQ-028 frame_start_in coincident with a DRAIN exit SHALL count as overrun; no back-to-back start.

Reset
REQ-029 When rst_in=0 at a clock edge, the block SHALL enter IDLE.
REQ-030 Reset SHALL clear all counters, pending flags and the valid delay line.
REQ-031 Reset SHALL drive every output to 0, including addr_out=0, mid-frame included.
REQ-032 The first frame_start_in honoured SHALL be the one sampled with rst_in=1.

Structure
REQ-033 State enum and default parameter constants SHALL live in shared package render_pkg.
REQ-034 The BRAM_LATENCY valid delay SHALL be a sub-module valid_pipe, parameterised by depth.
REQ-035 Vertex memory and the rotation datapath SHALL be external to this block.

Verification
REQ-036 Reset, then frame_start with no requests: 256 contiguous addr 0..255; vtx_valid_out high 256 cycles, lagging addr by 2; datapath echo -> frame_done_out exactly once.
REQ-037 inc_req pulse during IDLE, then frame_start: inc_out 1 cycle, 20 quiet cycles, then ISSUE.
REQ-038 inc_req and dec_req both pending, then frame_start: no step pulse; SETTLE skipped.
REQ-039 frame_start mid-ISSUE: overrun_out 1 cycle, addresses uninterrupted.
REQ-040 Datapath returns only 250 valids: timeout_out after 64 DRAIN cycles, no frame_done_out, back to IDLE.
REQ-041 rst_in=0 at address 100: next cycle all outputs 0 and IDLE; new frame starts from addr 0.
